// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// Frame FSM states, byte width and shift direction names.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    CHK
  } state_e;

  localparam int BYTE_W = 8;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

endpackage

// File: rtl/bit_assembler.sv
// Serial-to-parallel bit window for the frame receiver.
// Exposes both the current window and the value it takes on this edge.
module bit_assembler
  import serial_rx_pkg::*;
#(
  parameter string SHIFT_DIRECTION = DIR_LEFT
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic              enable,
  input  logic              shiftin,
  output logic [BYTE_W-1:0] win,
  output logic [BYTE_W-1:0] win_next
);

  localparam bit IS_RIGHT = (SHIFT_DIRECTION == DIR_RIGHT);

  logic [BYTE_W-1:0] win_q;

  always_comb begin
    if (IS_RIGHT) win_next = {shiftin, win_q[BYTE_W-1:1]};
    else          win_next = {win_q[BYTE_W-2:0], shiftin};
  end

  always_ff @(posedge clock) begin
    if (sclr)        win_q <= '0;
    else if (enable) win_q <= win_next;
  end

  assign win = win_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, payload assembly, XOR checksum.
// Every output is registered; strobes last exactly one cycle.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD       = 8'hA5,
  parameter int         FRAME_BYTES     = 4,
  parameter string      SHIFT_DIRECTION = DIR_LEFT
) (
  input  logic       clock,
  input  logic       sclr,
  input  logic       enable,
  input  logic       shiftin,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       checksum_err,
  output logic       locked,
  output logic [7:0] frame_count
);

  logic [BYTE_W-1:0] win_unused;
  logic [BYTE_W-1:0] win_nxt;

  state_e state_q, state_d;
  logic [3:0] fill_q, fill_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] xor_q, xor_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] cnt_q, cnt_d;
  logic dv_q, dv_d;
  logic fs_q, fs_d;
  logic fd_q, fd_d;
  logic err_q, err_d;
  logic lock_q, lock_d;

  logic match;
  logic last_bit;
  logic last_byte;

  bit_assembler #(
    .SHIFT_DIRECTION(SHIFT_DIRECTION)
  ) u_asm (
    .clock   (clock),
    .sclr    (sclr),
    .enable  (enable),
    .shiftin (shiftin),
    .win     (win_unused),
    .win_next(win_nxt)
  );

  // A match needs eight real bits behind it, so a fresh window can't fake sync.
  assign match     = (fill_q >= 4'd7) && (win_nxt == SYNC_WORD);
  assign last_bit  = (bit_q == 3'd7);
  assign last_byte = (byte_q == 8'(FRAME_BYTES - 1));

  always_ff @(posedge clock) begin
    if (sclr) state_q <= HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        HUNT:    if (match) state_d = DATA;
        DATA:    if (last_bit && last_byte) state_d = CHK;
        CHK:     if (last_bit) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    fill_d = fill_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    xor_d  = xor_q;
    dout_d = dout_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    dv_d   = 1'b0;
    fs_d   = 1'b0;
    fd_d   = 1'b0;
    if (enable) begin
      bit_d = bit_q + 3'd1;
      unique case (state_q)
        HUNT: begin
          if (fill_q != 4'd8) fill_d = fill_q + 4'd1;
          if (match) begin
            bit_d  = '0;
            byte_d = '0;
            xor_d  = '0;
            fs_d   = 1'b1;
          end
        end
        DATA: begin
          if (last_bit) begin
            dout_d = win_nxt;
            dv_d   = 1'b1;
            xor_d  = xor_q ^ win_nxt;
            byte_d = byte_q + 8'd1;
          end
        end
        CHK: begin
          if (last_bit) begin
            fd_d   = 1'b1;
            err_d  = (win_nxt != xor_q);
            fill_d = '0;
            if (win_nxt == xor_q) cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    // Held through the frame_done cycle, dropped the cycle after.
    lock_d = (state_d != HUNT) || fd_d;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      fill_q <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      xor_q  <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      dv_q   <= 1'b0;
      fs_q   <= 1'b0;
      fd_q   <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      xor_q  <= xor_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      dv_q   <= dv_d;
      fs_q   <= fs_d;
      fd_q   <= fd_d;
      lock_q <= lock_d;
    end
  end

  assign data_out     = dout_q;
  assign data_valid   = dv_q;
  assign frame_start  = fs_q;
  assign frame_done   = fd_q;
  assign checksum_err = err_q;
  assign locked       = lock_q;
  assign frame_count  = cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx, MSB-first and LSB-first.
// Expected bytes and frame status are queued as the stream is driven.
module tb_serial_frame_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] cnt;
  } done_t;

  logic clock;
  logic sclr;
  logic enable;
  logic shiftin;
  logic shiftin_r;
  logic sel_r;

  logic [7:0] dout_l, dout_r;
  logic dv_l, dv_r, fs_l, fs_r, fd_l, fd_r;
  logic err_l, err_r, lock_l, lock_r;
  logic [7:0] cnt_l, cnt_r;

  logic [7:0] m_dout, m_cnt;
  logic m_dv, m_fs, m_fd, m_err, m_lock;

  int n_cmp;
  int n_bad;
  int sent_bits;
  int frame_base;
  int fs_seen;
  int exp_cnt;
  logic dv_prev;
  logic fs_prev;
  logic lock_chk;

  logic [7:0] exp_byte_q[$];
  done_t exp_done_q[$];
  logic [7:0] pay [4];

  serial_frame_rx #(
    .SYNC_WORD(8'hA5),
    .FRAME_BYTES(4),
    .SHIFT_DIRECTION("LEFT")
  ) u_dut (
    .clock(clock),
    .sclr(sclr),
    .enable(enable),
    .shiftin(shiftin),
    .data_out(dout_l),
    .data_valid(dv_l),
    .frame_start(fs_l),
    .frame_done(fd_l),
    .checksum_err(err_l),
    .locked(lock_l),
    .frame_count(cnt_l)
  );

  serial_frame_rx #(
    .SYNC_WORD(8'hA5),
    .FRAME_BYTES(4),
    .SHIFT_DIRECTION("RIGHT")
  ) u_dut_r (
    .clock(clock),
    .sclr(sclr),
    .enable(enable),
    .shiftin(shiftin_r),
    .data_out(dout_r),
    .data_valid(dv_r),
    .frame_start(fs_r),
    .frame_done(fd_r),
    .checksum_err(err_r),
    .locked(lock_r),
    .frame_count(cnt_r)
  );

  assign m_dout = sel_r ? dout_r : dout_l;
  assign m_dv   = sel_r ? dv_r   : dv_l;
  assign m_fs   = sel_r ? fs_r   : fs_l;
  assign m_fd   = sel_r ? fd_r   : fd_l;
  assign m_err  = sel_r ? err_r  : err_l;
  assign m_lock = sel_r ? lock_r : lock_l;
  assign m_cnt  = sel_r ? cnt_r  : cnt_l;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock)
    if (enable && !sclr) sent_bits <= sent_bits + 1;

  always @(negedge clock) begin
    if (lock_chk) chk("locked_fall", 32'(m_lock), 32'd0);
    lock_chk = 1'b0;
    if (m_dv) begin
      chk("dv_width", 32'(dv_prev), 32'd0);
      if (exp_byte_q.size() == 0) chk("dv_unexpected", 32'd1, 32'd0);
      else chk("data_out", 32'(m_dout), 32'(exp_byte_q.pop_front()));
    end
    if (m_fs) begin
      fs_seen++;
      chk("fs_width", 32'(fs_prev), 32'd0);
      chk("fs_position", 32'(sent_bits - frame_base), 32'd16);
    end
    if (m_fd) begin
      chk("locked_at_done", 32'(m_lock), 32'd1);
      if (exp_done_q.size() == 0) chk("fd_unexpected", 32'd1, 32'd0);
      else begin
        done_t e;
        e = exp_done_q.pop_front();
        chk("checksum_err", 32'(m_err), 32'(e.err));
        chk("frame_count", 32'(m_cnt), 32'(e.cnt));
      end
      lock_chk = 1'b1;
    end
    dv_prev = m_dv;
    fs_prev = m_fs;
  end

  task automatic cyc(input logic en, input logic b);
    enable = en;
    if (sel_r) begin
      shiftin_r = b;
      shiftin   = 1'b0;
    end else begin
      shiftin   = b;
      shiftin_r = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        cyc(1'b0, 1'($urandom_range(0, 1)));
      cyc(1'b1, sel_r ? v[i] : v[7-i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] ck, input bit gaps);
    logic [7:0] x;
    done_t d;
    x = '0;
    frame_base = sent_bits;
    send_byte(8'h00, gaps);
    send_byte(8'hA5, gaps);
    for (int i = 0; i < 4; i++) begin
      exp_byte_q.push_back(pay[i]);
      x = x ^ pay[i];
      send_byte(pay[i], gaps);
    end
    d.err = (ck != x);
    if (!d.err) exp_cnt++;
    d.cnt = 8'(exp_cnt);
    exp_done_q.push_back(d);
    send_byte(ck, gaps);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sent_bits = 0;
    frame_base = 0;
    fs_seen = 0;
    exp_cnt = 0;
    dv_prev = 1'b0;
    fs_prev = 1'b0;
    lock_chk = 1'b0;
    sel_r = 1'b0;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    sclr = 1'b1;
    enable = 1'b0;
    shiftin = 1'b0;
    shiftin_r = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("rst_data_out", 32'(dout_l), 32'd0);
    chk("rst_data_valid", 32'(dv_l), 32'd0);
    chk("rst_frame_start", 32'(fs_l), 32'd0);
    chk("rst_frame_done", 32'(fd_l), 32'd0);
    chk("rst_checksum_err", 32'(err_l), 32'd0);
    chk("rst_locked", 32'(lock_l), 32'd0);
    chk("rst_frame_count", 32'(cnt_l), 32'd0);
    chk("rst_locked_r", 32'(lock_r), 32'd0);
    sclr = 1'b0;
    cyc(1'b0, 1'b0);

    frame_base = sent_bits;
    send_byte(8'h00, 1'b0);
    send_byte(8'hA5, 1'b0);
    exp_byte_q.push_back(8'h11);
    send_byte(8'h11, 1'b0);
    exp_byte_q.push_back(8'h22);
    send_byte(8'h22, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    sclr = 1'b1;
    cyc(1'b1, 1'b1);
    sclr = 1'b0;
    chk("abort_locked", 32'(lock_l), 32'd0);
    chk("abort_frame_count", 32'(cnt_l), 32'd0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
    exp_cnt = 0;

    send_frame(8'h44, 1'b0);
    send_frame(8'h45, 1'b0);
    send_frame(8'h44, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    chk("left_final_count", 32'(cnt_l), 32'd2);

    sel_r = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    send_frame(8'h44, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);

    chk("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    chk("dones_left", 32'(exp_done_q.size()), 32'd0);
    chk("frame_starts", 32'(fs_seen), 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
